// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : PC / instruction-fetch stage feeding the IF/ID pipeline register
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [6:0]  imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  logic [1:0]  state, state_next;
  logic [31:0] pc, pc_next;
  logic        if_valid_next, fetch_fault_next;
  logic [31:0] if_pc_next, if_instr_next, fault_pc_next;
  logic        redirect_misaligned, pc_out_of_range;

  assign imem_addr           = pc[8:2];
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign pc_out_of_range     = (pc[31:9] != 23'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= 32'd0;
      if_instr    <= NOP_INSTR;
      fetch_fault <= 1'b0;
      fault_pc    <= 32'd0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      if_valid    <= if_valid_next;
      if_pc       <= if_pc_next;
      if_instr    <= if_instr_next;
      fetch_fault <= fetch_fault_next;
      fault_pc    <= fault_pc_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT: state_next = (redirect_valid && redirect_misaligned) ? FAULT : RUN;
      RUN: begin
        if (redirect_valid)
          state_next = redirect_misaligned ? FAULT : RUN;
        else if (!stall && pc_out_of_range)
          state_next = FAULT;
      end
      FAULT:   state_next = FAULT;
      default: state_next = BOOT;
    endcase
  end

  // Redirects are honoured in BOOT as well; only RUN fetches or stalls.
  always_comb begin
    pc_next          = pc;
    if_valid_next    = if_valid;
    if_pc_next       = if_pc;
    if_instr_next    = if_instr;
    fetch_fault_next = fetch_fault;
    fault_pc_next    = fault_pc;
    case (state)
      BOOT, RUN: begin
        if (redirect_valid && redirect_misaligned) begin
          if_valid_next    = 1'b0;
          if_instr_next    = NOP_INSTR;
          fetch_fault_next = 1'b1;
          fault_pc_next    = redirect_pc;
        end else if (redirect_valid) begin
          pc_next       = redirect_pc;
          if_valid_next = 1'b0;
          if_instr_next = NOP_INSTR;
        end else if (state == RUN && !stall) begin
          if (pc_out_of_range) begin
            if_valid_next    = 1'b0;
            if_instr_next    = NOP_INSTR;
            fetch_fault_next = 1'b1;
            fault_pc_next    = pc;
          end else begin
            if_valid_next = 1'b1;
            if_pc_next    = pc;
            if_instr_next = imem_instr;
            pc_next       = pc + 32'd4;
          end
        end
      end
      default: begin
        if_valid_next = 1'b0;
        if_instr_next = NOP_INSTR;
      end
    endcase
  end

endmodule

`default_nettype wire
